// File: rtl/axi256_ctrl_pkg.sv
// Shared types and defaults for the 256-bit AXI writer arbiter.
package axi256_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 256;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/axi256_write_arbiter_if.sv
// Requester and writer-side signals of the arbiter, bundled for port use.
interface axi256_write_arbiter_if
    import axi256_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_OUT = 4
);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        cmp_valid;
    logic                      writer_start;
    logic [ADDR_W-1:0]         writer_addr;
    logic [DATA_W-1:0]         writer_data;
    logic                      writer_ready;
    logic                      writer_idle;
    logic                      writer_done;
    logic [OUT_W-1:0]          outstanding;
    logic                      busy;
    logic                      err_spurious;

    // master: requesters plus writer; slave: the arbiter itself
    modport master (
        output req_valid, req_addr, req_data, writer_ready, writer_idle, writer_done,
        input  req_ready, cmp_valid, writer_start, writer_addr, writer_data,
               outstanding, busy, err_spurious
    );

    modport slave (
        input  req_valid, req_addr, req_data, writer_ready, writer_idle, writer_done,
        output req_ready, cmp_valid, writer_start, writer_addr, writer_data,
               outstanding, busy, err_spurious
    );

endinterface

// File: rtl/axi256_id_fifo.sv
// In-order FIFO of issuer indices for commands awaiting writer_done.
module axi256_id_fifo
    import axi256_ctrl_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [ID_W-1:0]            i_push_id,
    input  logic                       i_pop,
    output logic [ID_W-1:0]            o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi256_write_arbiter.sv
// Round-robin sharing of one AXI writer between NUM_REQ requesters, with
// in-order routing of writer_done back to the issuing requester.
module axi256_write_arbiter
    import axi256_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_OUT = 4
) (
    input logic                   clock,
    input logic                   reset,
    axi256_write_arbiter_if.slave bus
);
    localparam int ID_W  = id_w(NUM_REQ);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    state_e              r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_cur_id;
    logic                r_writer_start;
    logic [ADDR_W-1:0]   r_writer_addr;
    logic [DATA_W-1:0]   r_writer_data;
    logic [NUM_REQ-1:0]  r_cmp_valid;
    logic                r_err_spurious;

    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_transfer;
    logic                w_consume;
    logic                w_bypass;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;
    logic [ID_W-1:0]     w_fifo_head;
    logic [OUT_W-1:0]    w_fifo_count;
    logic [OUT_W-1:0]    w_outstanding;
    logic                w_credit;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_grant_vld && bus.req_valid[rr_idx(r_last_grant, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = rr_idx(r_last_grant, k);
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_outstanding = w_fifo_count + OUT_W'(r_state == ISSUE);
    assign w_credit      = (w_outstanding < OUT_W'(MAX_OUT));
    // No grant while reset is held, so req_ready reads 0 during reset.
    assign w_req_ready   = (reset && r_state == IDLE && w_credit && w_grant_vld)
                           ? onehot(w_grant_idx) : '0;
    assign w_transfer    = |(bus.req_valid & w_req_ready);
    assign w_consume     = (r_state == ISSUE) && bus.writer_ready;
    assign w_bypass      = w_consume && bus.writer_done && w_fifo_empty;
    assign w_push        = w_consume && !w_bypass;
    assign w_pop         = bus.writer_done && !w_fifo_empty;

    axi256_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_push),
        .i_push_id (r_cur_id),
        .i_pop     (w_pop),
        .o_head    (w_fifo_head),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_cur_id       <= '0;
            r_writer_start <= 1'b0;
            r_writer_addr  <= '0;
            r_writer_data  <= '0;
            r_cmp_valid    <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_cmp_valid <= w_bypass ? onehot(r_cur_id)
                         : (w_pop ? onehot(w_fifo_head) : '0);
            if (bus.writer_done && w_fifo_empty && !w_bypass) r_err_spurious <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_state        <= ISSUE;
                        r_writer_start <= 1'b1;
                        r_writer_addr  <= w_sel_addr;
                        r_writer_data  <= w_sel_data;
                        r_cur_id       <= w_grant_idx;
                        r_last_grant   <= w_grant_idx;
                    end
                end
                ISSUE: begin
                    if (bus.writer_ready) begin
                        r_state        <= IDLE;
                        r_writer_start <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.cmp_valid    = r_cmp_valid;
    assign bus.writer_start = r_writer_start;
    assign bus.writer_addr  = r_writer_addr;
    assign bus.writer_data  = r_writer_data;
    assign bus.outstanding  = w_outstanding;
    assign bus.busy         = (w_outstanding != '0) || !bus.writer_idle;
    assign bus.err_spurious = r_err_spurious;

endmodule
